// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// irq_pkg : register map, TCON fields, FSM states and helpers for the
//           interrupt controller / interval timer.   Rev 1.0
// ============================================================================
package irq_pkg;

  localparam logic [31:0] OFS_TH     = 32'h0000_0000;
  localparam logic [31:0] OFS_TL     = 32'h0000_0004;
  localparam logic [31:0] OFS_TCON   = 32'h0000_0008;
  localparam logic [31:0] OFS_IMASK  = 32'h0000_000C;
  localparam logic [31:0] OFS_IPEND  = 32'h0000_0010;
  localparam logic [31:0] OFS_ICAUSE = 32'h0000_0014;

  localparam int unsigned TCON_EN     = 0;
  localparam int unsigned TCON_IEN    = 1;
  localparam int unsigned TCON_STATUS = 2;

  localparam logic [31:0] XADR = 32'h8000_0008;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [3:0] lowest_set(input logic [8:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_interval_timer.sv
`default_nettype none
// ============================================================================
// irq_interval_timer : TH/TL/TCON registers with free-running increment and
//                      reload on wrap; emits a one-cycle wrap pulse.  Rev 1.0
// ============================================================================
module irq_interval_timer
  import irq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_th_we,
  input  logic        i_tl_we,
  input  logic        i_tcon_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_th,
  output logic [31:0] o_tl,
  output logic [2:0]  o_tcon,
  output logic        o_wrap
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        wrap;

  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    wrap   = 1'b0;
    if (i_th_we)   th_d   = i_wdata;
    if (i_tcon_we) tcon_d = i_wdata[2:0];
    // A software TL write overrides both the increment and the reload.
    if (i_tl_we) begin
      tl_d = i_wdata;
    end else if (tcon_q[TCON_EN]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d = th_q;
        wrap = 1'b1;
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (wrap) tcon_d[TCON_STATUS] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign o_th   = th_q;
  assign o_tl   = tl_q;
  assign o_tcon = tcon_q;
  assign o_wrap = wrap;

endmodule
`default_nettype wire

// File: rtl/irq_timer_controller.sv
`default_nettype none
// ============================================================================
// irq_timer_controller : memory-mapped interrupt controller + interval timer
//                        driving the CPU IRQ line; blocks nesting in kernel mode.
// Rev 1.0
// ============================================================================
module irq_timer_controller
  import irq_pkg::*;
#(
  parameter int          N_EXT     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             rd,
  input  logic             wr,
  output logic [31:0]      rdata,
  input  logic [N_EXT-1:0] irq_src,
  input  logic             pc_super,
  input  logic             irq_taken,
  output logic             irq,
  output logic [N_EXT:0]   led_irq
);

  localparam int NSRC = N_EXT + 1;

  logic [31:0]      off;
  logic             we_th, we_tl, we_tcon, we_imask, we_ipend;
  logic [31:0]      th, tl;
  logic [2:0]       tcon;
  logic             wrap;
  logic [NSRC-1:0]  imask_q, imask_d;
  logic [NSRC-1:0]  ipend_q, ipend_d;
  logic [NSRC-1:0]  hw_set, w1c, pend_act;
  logic [N_EXT-1:0] src_prev_q, src_prev_d;
  logic [3:0]       icause_q, icause_d, win_idx;
  state_e           state_q, state_d;

  // Exact offset match: unaligned or out-of-window accesses hit nothing.
  assign off      = addr - BASE_ADDR;
  assign we_th    = wr && (off == OFS_TH);
  assign we_tl    = wr && (off == OFS_TL);
  assign we_tcon  = wr && (off == OFS_TCON);
  assign we_imask = wr && (off == OFS_IMASK);
  assign we_ipend = wr && (off == OFS_IPEND);

  irq_interval_timer u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .i_th_we   (we_th),
    .i_tl_we   (we_tl),
    .i_tcon_we (we_tcon),
    .i_wdata   (wdata),
    .o_th      (th),
    .o_tl      (tl),
    .o_tcon    (tcon),
    .o_wrap    (wrap)
  );

  assign hw_set   = {irq_src & ~src_prev_q, wrap & tcon[TCON_IEN]};
  assign w1c      = we_ipend ? wdata[NSRC-1:0] : '0;
  assign pend_act = ipend_q & imask_q;
  assign win_idx  = lowest_set(9'(pend_act));

  always_comb begin
    imask_d    = imask_q;
    icause_d   = icause_q;
    state_d    = state_q;
    src_prev_d = irq_src;
    if (we_imask) imask_d = wdata[NSRC-1:0];
    // Hardware set is OR-ed in after the clear so it wins a collision.
    ipend_d = (ipend_q & ~w1c) | hw_set;
    case (state_q)
      IDLE: begin
        if ((|pend_act) && !pc_super) state_d = ASSERT;
      end
      ASSERT: begin
        if (irq_taken) begin
          icause_d = win_idx;
          state_d  = SERVICE;
        end else if (!(|pend_act)) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (!pc_super) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imask_q    <= '0;
      ipend_q    <= '0;
      icause_q   <= '0;
      src_prev_q <= '0;
      state_q    <= IDLE;
    end else begin
      imask_q    <= imask_d;
      ipend_q    <= ipend_d;
      icause_q   <= icause_d;
      src_prev_q <= src_prev_d;
      state_q    <= state_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        OFS_TH:     rdata = th;
        OFS_TL:     rdata = tl;
        OFS_TCON:   rdata = {29'd0, tcon};
        OFS_IMASK:  rdata = 32'(imask_q);
        OFS_IPEND:  rdata = 32'(ipend_q);
        OFS_ICAUSE: rdata = {28'd0, icause_q};
        default:    rdata = '0;
      endcase
    end
  end

  assign irq     = (state_q == ASSERT);
  assign led_irq = ipend_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_timer_controller.sv
`default_nettype none
// ============================================================================
// tb_irq_timer_controller : directed + randomized bench with a cycle-level
//                           reference model of the controller.  Rev 1.0
// ============================================================================
module tb_irq_timer_controller;

  localparam int          N_EXT = 4;
  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam logic [31:0] A_TH = 32'h00, A_TL = 32'h04, A_TCON = 32'h08;
  localparam logic [31:0] A_IMASK = 32'h0C, A_IPEND = 32'h10, A_ICAUSE = 32'h14;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      addr, wdata, rdata;
  logic             rd, wr;
  logic [N_EXT-1:0] irq_src;
  logic             pc_super, irq_taken, irq;
  logic [N_EXT:0]   led_irq;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0]      m_th, m_tl;
  logic [2:0]       m_tcon;
  logic [N_EXT:0]   m_imask, m_ipend;
  logic [3:0]       m_icause;
  logic [N_EXT-1:0] m_prev;
  bit               m_irq, m_inh;

  irq_timer_controller #(.N_EXT(N_EXT), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .rd        (rd),
    .wr        (wr),
    .rdata     (rdata),
    .irq_src   (irq_src),
    .pc_super  (pc_super),
    .irq_taken (irq_taken),
    .irq       (irq),
    .led_irq   (led_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_th = '0; m_tl = '0; m_tcon = '0; m_imask = '0; m_ipend = '0;
    m_icause = '0; m_prev = '0; m_irq = 0; m_inh = 0;
  endtask

  function automatic int reg_index(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o >= 32'h18 || o[1:0] != 2'b00) return -1;
    return int'(o >> 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, input logic r);
    if (!r) return '0;
    case (reg_index(a))
      0:       return m_th;
      1:       return m_tl;
      2:       return {29'd0, m_tcon};
      3:       return 32'(m_imask);
      4:       return 32'(m_ipend);
      5:       return {28'd0, m_icause};
      default: return '0;
    endcase
  endfunction

  function automatic logic [3:0] m_lowest(input logic [N_EXT:0] v);
    for (int i = 0; i <= N_EXT; i++) if (v[i]) return 4'(i);
    return 4'd0;
  endfunction

  // Advance the model by one clock using the inputs held across the edge.
  task automatic model_clock();
    int             idx;
    logic [N_EXT:0] act, clr, set;
    logic           wrp;
    logic [31:0]    tl_n;
    logic [2:0]     tcon_n;
    if (!reset) begin
      model_reset();
      return;
    end
    idx  = wr ? reg_index(addr) : -1;
    act  = m_ipend & m_imask;
    wrp  = m_tcon[0] && (m_tl == 32'hFFFF_FFFF) && (idx != 1);
    if (idx == 1)       tl_n = wdata;
    else if (m_tcon[0]) tl_n = (m_tl == 32'hFFFF_FFFF) ? m_th : m_tl + 32'd1;
    else                tl_n = m_tl;
    tcon_n = (idx == 2) ? wdata[2:0] : m_tcon;
    if (wrp) tcon_n[2] = 1'b1;
    set = {irq_src & ~m_prev, wrp & m_tcon[1]};
    clr = (idx == 4) ? wdata[N_EXT:0] : '0;
    if (m_inh) begin
      if (!pc_super) m_inh = 0;
    end else if (m_irq) begin
      if (irq_taken) begin
        m_irq = 0; m_inh = 1; m_icause = m_lowest(act);
      end else if (act == '0) begin
        m_irq = 0;
      end
    end else if (act != '0 && !pc_super) begin
      m_irq = 1;
    end
    m_ipend = (m_ipend & ~clr) | set;
    if (idx == 0) m_th = wdata;
    if (idx == 3) m_imask = wdata[N_EXT:0];
    m_tl   = tl_n;
    m_tcon = tcon_n;
    m_prev = irq_src;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("irq", 32'(irq), 32'(m_irq));
    chk("led_irq", 32'(led_irq), 32'(m_ipend));
    chk("rdata", rdata, m_read(addr, rd));
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] ofs, input logic [31:0] data);
    addr = BASE + ofs; wdata = data; wr = 1'b1;
    tick();
    wr = 1'b0; addr = '0; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
    addr = BASE + ofs; rd = 1'b1;
    #1;
    chk(tag, rdata, exp);
    chk({tag, "_model"}, rdata, m_read(addr, 1'b1));
    rd = 1'b0; addr = '0;
  endtask

  initial begin
    reset = 1'b0; addr = '0; wdata = '0; rd = 1'b0; wr = 1'b0;
    irq_src = '0; pc_super = 1'b0; irq_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Reset state
    for (int i = 0; i < 6; i++) rd_chk("t1_reset_read", 32'(4 * i), 32'd0);
    repeat (100) tick();
    chk("t1_irq_quiet", 32'(irq), 32'd0);

    // Timer wrap raises IPEND[0], irq follows one cycle later
    wr_reg(A_TH, 32'hFFFF_FFFC);
    wr_reg(A_TL, 32'hFFFF_FFFC);
    wr_reg(A_IMASK, 32'h1);
    wr_reg(A_TCON, 32'h3);
    repeat (3) tick();
    rd_chk("t2_ipend_before_wrap", A_IPEND, 32'h0);
    tick();
    rd_chk("t2_ipend_wrap", A_IPEND, 32'h1);
    chk("t2_irq_not_yet", 32'(irq), 32'd0);
    tick();
    chk("t2_irq_asserted", 32'(irq), 32'd1);
    pc_super = 1'b1; irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    rd_chk("t2_icause", A_ICAUSE, 32'h0);
    chk("t2_irq_dropped", 32'(irq), 32'd0);
    rd_chk("t2_tl_reloaded", A_TL, 32'hFFFF_FFFE);
    rd_chk("t2_tcon_status", A_TCON, 32'h7);
    wr_reg(A_TCON, 32'h0);
    wr_reg(A_IPEND, 32'h1F);
    pc_super = 1'b0;
    repeat (2) tick();
    rd_chk("t2_ipend_cleared", A_IPEND, 32'h0);

    // Priority between simultaneous external edges
    wr_reg(A_IMASK, 32'h1F);
    irq_src = 4'b0101;
    tick();
    irq_src = 4'b0000;
    rd_chk("t3_ipend", A_IPEND, 32'h0A);
    tick();
    chk("t3_irq", 32'(irq), 32'd1);
    pc_super = 1'b1; irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
    rd_chk("t3_icause", A_ICAUSE, 32'h1);

    // No nesting in kernel mode; W1C withdraws a pending request
    wr_reg(A_IPEND, 32'h0A);
    irq_src = 4'b1000;
    tick();
    rd_chk("t4_ipend_in_service", A_IPEND, 32'h10);
    chk("t4_irq_blocked", 32'(irq), 32'd0);
    repeat (3) tick();
    chk("t4_irq_still_blocked", 32'(irq), 32'd0);
    pc_super = 1'b0;
    tick();
    chk("t4_irq_return_plus1", 32'(irq), 32'd0);
    tick();
    chk("t4_irq_return_plus2", 32'(irq), 32'd1);
    wr_reg(A_IPEND, 32'h10);
    chk("t4_irq_during_clear", 32'(irq), 32'd1);
    tick();
    chk("t4_irq_withdrawn", 32'(irq), 32'd0);
    irq_src = 4'b0000;
    tick();

    // Set beats W1C on the same bit
    wr_reg(A_TH, 32'hFFFF_FFF0);
    wr_reg(A_TL, 32'hFFFF_FFFE);
    wr_reg(A_TCON, 32'h3);
    tick();
    wr_reg(A_IPEND, 32'h1);
    rd_chk("t5_ipend_collision", A_IPEND, 32'h1);
    rd_chk("t5_tcon", A_TCON, 32'h7);
    rd_chk("t5_tl_reload", A_TL, 32'hFFFF_FFF0);
    for (int i = 0; i < 5 && !irq; i++) tick();
    chk("t5_irq_asserted", 32'(irq), 32'd1);

    // Asynchronous reset in the middle of ASSERT
    #2 reset = 1'b0;
    #1;
    chk("t6_irq_immediate", 32'(irq), 32'd0);
    chk("t6_led_immediate", 32'(led_irq), 32'd0);
    model_reset();
    tick();
    for (int i = 0; i < 6; i++) rd_chk("t6_reset_read", 32'(4 * i), 32'd0);
    #1 reset = 1'b1;
    repeat (5) tick();
    chk("t6_irq_idle", 32'(irq), 32'd0);
    rd_chk("t6_tl_stopped", A_TL, 32'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      int sel;
      sel = int'($urandom_range(0, 7));
      rd  = ($urandom_range(0, 1) == 1);
      wr  = ($urandom_range(0, 3) == 0);
      addr = (sel == 7) ? $urandom : BASE + 32'(sel * 4);
      case (sel)
        0, 1:    wdata = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        2:       wdata = 32'($urandom_range(0, 7));
        default: wdata = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
      if ($urandom_range(0, 7) == 0) pc_super = ~pc_super;
      irq_taken = irq && ($urandom_range(0, 2) == 0);
      if (irq_taken) pc_super = 1'b1;
      tick();
    end
    rd = 1'b0; wr = 1'b0; irq_taken = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
